// File: rtl/int_pkg.sv
// Shared types and constants for the fixed-priority interrupt controller.
// Source index assignments match the peripheral wiring at the top level.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } int_state_t;

    localparam int INT_MAX_SRC    = 16;
    localparam int INT_SRC_SWITCH = 0;
    localparam int INT_SRC_KEYPAD = 1;
    localparam int INT_SRC_TIMER  = 2;

endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: index of the lowest set request bit.
module prio_enc #(
    parameter  int N_SRC = 4,
    localparam int VW    = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [VW-1:0]    index
);

    always_comb begin
        valid = |req;
        index = '0;
        // Scan downward so the lowest set bit is written last.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = VW'(i);
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Fixed-priority interrupt controller: masks level requests, raises irq with a
// frozen vector, acks the granted source after inta, and holds until eoi.
module int_controller
    import int_pkg::*;
#(
    parameter  int N_SRC = 4,
    localparam int VW    = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] src_int,
    output logic [N_SRC-1:0] src_ack,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_din,
    output logic [N_SRC-1:0] mask,
    output logic [N_SRC-1:0] pending,
    output logic             irq,
    input  logic             inta,
    output logic [VW-1:0]    vector,
    output logic             in_service,
    input  logic             eoi
);

    int_state_t       state_q, state_d;
    logic             irq_q, irq_d;
    logic [VW-1:0]    vec_q, vec_d;
    logic             ins_q, ins_d;
    logic [N_SRC-1:0] ack_q, ack_d;
    logic [N_SRC-1:0] mask_q;

    logic             enc_valid;
    logic [VW-1:0]    enc_index;

    assign pending = src_int & ~mask_q;

    prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .req   (pending),
        .valid (enc_valid),
        .index (enc_index)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            vec_q   <= '0;
            ins_q   <= 1'b0;
            ack_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            ins_q   <= ins_d;
            ack_q   <= ack_d;
            if (mask_we) begin
                mask_q <= mask_din;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        vec_d   = vec_q;
        ins_d   = ins_q;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    vec_d   = enc_index;
                    irq_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // inta takes precedence over a same-cycle cancel.
                if (inta) begin
                    irq_d        = 1'b0;
                    ack_d[vec_q] = 1'b1;
                    ins_d        = 1'b1;
                    state_d      = SERVICE;
                end else if (!pending[vec_q]) begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    ins_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                irq_d   = 1'b0;
                ins_d   = 1'b0;
            end
        endcase
    end

    assign mask       = mask_q;
    assign irq        = irq_q;
    assign vector     = vec_q;
    assign in_service = ins_q;
    assign src_ack    = ack_q;

endmodule

// File: tb/tb_int_controller.sv
// Randomised and directed checks of int_controller against a cycle-level
// behavioural model of the request / acknowledge / end-of-interrupt protocol.
module tb_int_controller;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] src_int;
    logic [N-1:0] src_ack;
    logic         mask_we;
    logic [N-1:0] mask_din;
    logic [N-1:0] mask;
    logic [N-1:0] pending;
    logic         irq;
    logic         inta;
    logic [W-1:0] vector;
    logic         in_service;
    logic         eoi;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 = waiting, 1 = requesting CPU, 2 = CPU in handler.
    int           m_phase;
    logic         m_irq;
    logic [W-1:0] m_vec;
    logic         m_ins;
    logic [N-1:0] m_ack;
    logic [N-1:0] m_mask;

    always #5 clk = ~clk;

    int_controller #(.N_SRC(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_int    (src_int),
        .src_ack    (src_ack),
        .mask_we    (mask_we),
        .mask_din   (mask_din),
        .mask       (mask),
        .pending    (pending),
        .irq        (irq),
        .inta       (inta),
        .vector     (vector),
        .in_service (in_service),
        .eoi        (eoi)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return W'(i);
        end
        return '0;
    endfunction

    task automatic model_edge();
        logic [N-1:0] pend;
        pend = src_int & ~m_mask;
        if (!rst_n) begin
            m_phase = 0; m_irq = 0; m_vec = '0;
            m_ins = 0; m_ack = '0; m_mask = '0;
            return;
        end
        m_ack = '0;
        if (m_phase == 0) begin
            if (pend != 0) begin
                m_vec = lowest(pend);
                m_irq = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (inta) begin
                m_ack = N'(1) << m_vec;
                m_irq = 0; m_ins = 1; m_phase = 2;
            end else if (pend[m_vec] == 1'b0) begin
                m_irq = 0; m_phase = 0;
            end
        end else if (eoi) begin
            m_ins = 0; m_phase = 0;
        end
        if (mask_we) m_mask = mask_din;
    endtask

    task automatic compare_all();
        chk("irq", 32'(irq), 32'(m_irq));
        chk("vector", 32'(vector), 32'(m_vec));
        chk("in_service", 32'(in_service), 32'(m_ins));
        chk("src_ack", 32'(src_ack), 32'(m_ack));
        chk("mask", 32'(mask), 32'(m_mask));
    endtask

    // Inputs already driven; check pending, clock once, check registered outputs.
    task automatic step();
        #1;
        chk("pending", 32'(pending), 32'(src_int & ~m_mask));
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_in();
        mask_we = 0; inta = 0; eoi = 0;
    endtask

    initial begin
        logic [N-1:0] drop;
        rst_n = 0; src_int = '0; mask_we = 0; mask_din = '0;
        inta = 0; eoi = 0;
        m_phase = 0; m_irq = 0; m_vec = '0; m_ins = 0;
        m_ack = '0; m_mask = '0;
        @(posedge clk); #1;
        step();
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_ack", 32'(src_ack), 32'd0);
        rst_n = 1;

        // Single source with full handshake.
        src_int = 4'b0100;
        step();
        chk("single_irq", 32'(irq), 32'd1);
        chk("single_vec", 32'(vector), 32'd2);
        step(); step();
        inta = 1; step(); inta = 0;
        chk("single_ack", 32'(src_ack), 32'b0100);
        step();
        chk("single_ack_gone", 32'(src_ack), 32'd0);
        src_int = '0;
        step();
        eoi = 1; step(); eoi = 0;
        chk("single_eoi", 32'(in_service), 32'd0);

        // Later higher-priority source does not pre-empt the frozen vector.
        src_int = 4'b1000; step(); step(); step();
        src_int = 4'b1001; step();
        chk("freeze_vec", 32'(vector), 32'd3);
        inta = 1; step(); inta = 0; step();
        src_int = 4'b0001; step();
        eoi = 1; step(); eoi = 0; step();
        chk("next_vec", 32'(vector), 32'd0);
        chk("next_irq", 32'(irq), 32'd1);
        inta = 1; step(); inta = 0; step();
        src_int = '0; eoi = 1; step(); eoi = 0;

        // Masking the requested source cancels without an ack.
        src_int = 4'b0010; step();
        mask_we = 1; mask_din = 4'b0010; step(); mask_we = 0;
        step();
        chk("cancel_irq", 32'(irq), 32'd0);
        chk("cancel_ack", 32'(src_ack), 32'd0);
        mask_we = 1; mask_din = '0; step(); mask_we = 0;
        step();
        chk("unmask_irq", 32'(irq), 32'd1);
        chk("unmask_vec", 32'(vector), 32'd1);

        // inta and mask in the same cycle: inta still wins.
        inta = 1; mask_we = 1; mask_din = 4'b0010; step();
        inta = 0; mask_we = 0;
        chk("race_ack", 32'(src_ack), 32'b0010);
        chk("race_ins", 32'(in_service), 32'd1);
        src_int = '0;
        inta = 1; step(); inta = 0;
        eoi = 1; step(); eoi = 0;
        mask_we = 1; mask_din = '0; step(); mask_we = 0;

        // Ignored strobes: inta in IDLE, eoi in REQ, inta in SERVICE.
        inta = 1; step(); inta = 0;
        chk("idle_inta_ack", 32'(src_ack), 32'd0);
        src_int = 4'b0100; step();
        eoi = 1; step(); eoi = 0;
        chk("req_eoi_irq", 32'(irq), 32'd1);
        inta = 1; step(); step(); inta = 0;
        chk("svc_inta_ack", 32'(src_ack), 32'd0);
        src_int = '0;

        // Reset mid-service with a request still held.
        src_int = 4'b0001; eoi = 1; step(); eoi = 0;
        step(); inta = 1; step(); inta = 0;
        rst_n = 0; step(); rst_n = 1;
        chk("rst_ins", 32'(in_service), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        step(); step();
        chk("rst_rearb", 32'(irq), 32'd1);

        // Random traffic; sources drop their request one cycle after ack.
        drop = '0;
        for (int c = 0; c < 4000; c++) begin
            src_int = src_int & ~drop;
            drop = m_ack;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) src_int[i] = 1'b1;
            end
            mask_we = ($urandom_range(0, 19) == 0);
            mask_din = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom);
            inta = ($urandom_range(0, 3) == 0);
            eoi = ($urandom_range(0, 4) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1;
        idle_in();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
